// File: rtl/ksz8851_init_seq.sv
// Post-reset bring-up sequencer for the KSZ8851 MAC/PHY register set.
// Define INIT_READBACK_EN to append the RXCR1 readback check as step 8.
`timescale 1ns/1ps
module ksz8851_init_seq #(
    parameter logic [47:0] MAC_ADDR = 48'hFA610E030000,
    parameter logic [15:0] TIMEOUT  = 16'd1024
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        initReq,
    output logic        initAck,
    output logic        cmdReq,
    input  logic        cmdAck,
    input  logic        dataValid,
    input  logic [15:0] rdData,
    output logic        isDMA,
    output logic        isWrite,
    output logic        isWord,
    output logic [7:0]  RegAddr,
    output logic [15:0] DataIn,
    output logic        initOK,
    output logic        ethIoError,
    output logic [3:0]  errStep
);
`ifdef INIT_READBACK_EN
    localparam logic [3:0] LAST_STEP = 4'd8;
`else
    localparam logic [3:0] LAST_STEP = 4'd7;
`endif

    typedef enum logic [3:0] {
        IDLE, START, ISSUE, WAIT_ACK, WAIT_DATA, DATA_DLY,
        CAPTURE, RELEASE, NEXT, DONE, ERROR, RESTART
    } state_t;

    state_t      state_q;
    logic [3:0]  step_q;
    logic [15:0] cnt_q;
    logic        initAck_q, cmdReq_q, isWrite_q;
    logic        initOK_q, ethIoError_q;
    logic [7:0]  RegAddr_q;
    logic [15:0] DataIn_q;
    logic [3:0]  errStep_q;

    logic        rom_wr;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data, rom_mask, rom_exp;
    logic        tmo, rd_ok, restart, goto_err;

    always_comb begin
        rom_wr   = 1'b1;
        rom_addr = 8'h00;
        rom_data = 16'h0000;
        rom_mask = 16'h0000;
        rom_exp  = 16'h0000;
        case (step_q)
            4'd0: begin
                rom_wr   = 1'b0;
                rom_addr = 8'hC0;
                rom_mask = 16'hFFF0;
                rom_exp  = 16'h8870;
            end
            4'd1: begin rom_addr = 8'h10; rom_data = MAC_ADDR[15:0];  end
            4'd2: begin rom_addr = 8'h12; rom_data = MAC_ADDR[31:16]; end
            4'd3: begin rom_addr = 8'h14; rom_data = MAC_ADDR[47:32]; end
            4'd4: begin rom_addr = 8'h84; rom_data = 16'h4000; end
            4'd5: begin rom_addr = 8'h86; rom_data = 16'h4000; end
            4'd6: begin rom_addr = 8'h70; rom_data = 16'h00EE; end
            4'd7: begin rom_addr = 8'h74; rom_data = 16'h7CE0; end
            4'd8: begin
                rom_wr   = 1'b0;
                rom_addr = 8'h74;
                rom_mask = 16'hFFFF;
                rom_exp  = 16'h7CE0;
            end
            default: rom_wr = 1'b0;
        endcase
    end

    assign tmo     = (cnt_q == TIMEOUT - 16'd1);
    assign rd_ok   = ((rdData & rom_mask) == rom_exp);
    assign restart = initReq && (state_q != IDLE) && (state_q != START);

    // Failure exits: a wait that made no progress before the deadline, or a bad readback.
    always_comb begin
        goto_err = 1'b0;
        case (state_q)
            WAIT_ACK:  goto_err = !cmdAck && tmo;
            WAIT_DATA: goto_err = !dataValid && tmo;
            RELEASE:   goto_err = cmdAck && tmo;
            CAPTURE:   goto_err = !rd_ok;
            default:   goto_err = 1'b0;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            step_q       <= 4'd0;
            cnt_q        <= 16'd0;
            initAck_q    <= 1'b0;
            cmdReq_q     <= 1'b0;
            isWrite_q    <= 1'b0;
            initOK_q     <= 1'b0;
            ethIoError_q <= 1'b0;
            RegAddr_q    <= 8'h00;
            DataIn_q     <= 16'h0000;
            errStep_q    <= 4'd0;
        end else begin
            initAck_q <= 1'b0;
            cnt_q     <= 16'd0;
            if (restart) begin
                cmdReq_q <= 1'b0;
                if (!cmdAck) begin
                    state_q   <= START;
                    initAck_q <= 1'b1;
                end else begin
                    state_q <= RESTART;
                end
            end else if (goto_err) begin
                cmdReq_q     <= 1'b0;
                ethIoError_q <= 1'b1;
                errStep_q    <= step_q;
                state_q      <= ERROR;
            end else begin
                case (state_q)
                    IDLE: if (initReq) begin
                        state_q   <= START;
                        initAck_q <= 1'b1;
                    end
                    START: begin
                        initOK_q     <= 1'b0;
                        ethIoError_q <= 1'b0;
                        step_q       <= 4'd0;
                        state_q      <= ISSUE;
                    end
                    ISSUE: begin
                        RegAddr_q <= rom_addr;
                        DataIn_q  <= rom_data;
                        isWrite_q <= rom_wr;
                        cmdReq_q  <= 1'b1;
                        state_q   <= WAIT_ACK;
                    end
                    WAIT_ACK: if (cmdAck) begin
                        if (isWrite_q) begin
                            cmdReq_q <= 1'b0;
                            state_q  <= RELEASE;
                        end else begin
                            state_q <= WAIT_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                    WAIT_DATA: if (dataValid) state_q <= DATA_DLY;
                               else cnt_q <= cnt_q + 16'd1;
                    DATA_DLY: state_q <= CAPTURE;
                    CAPTURE: begin
                        cmdReq_q <= 1'b0;
                        state_q  <= RELEASE;
                    end
                    RELEASE: begin
                        cmdReq_q <= 1'b0;
                        if (!cmdAck) state_q <= NEXT;
                        else cnt_q <= cnt_q + 16'd1;
                    end
                    NEXT: if (step_q == LAST_STEP) begin
                        initOK_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        step_q  <= step_q + 4'd1;
                        state_q <= ISSUE;
                    end
                    DONE: state_q <= IDLE;
                    ERROR: begin
                        cmdReq_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                    RESTART: if (!cmdAck) begin
                        state_q   <= START;
                        initAck_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign initAck    = initAck_q;
    assign cmdReq     = cmdReq_q;
    assign isDMA      = 1'b0;
    assign isWrite    = isWrite_q;
    assign isWord     = 1'b1;
    assign RegAddr    = RegAddr_q;
    assign DataIn     = DataIn_q;
    assign initOK     = initOK_q;
    assign ethIoError = ethIoError_q;
    assign errStep    = errStep_q;
endmodule

// File: tb/tb_ksz8851_init_seq.sv
// Scoreboard bench for ksz8851_init_seq with a small KSZ8851 driver model.
`timescale 1ns/1ps
module tb_ksz8851_init_seq;
`ifdef INIT_READBACK_EN
    localparam int NSTEP = 9;
`else
    localparam int NSTEP = 8;
`endif
    // {isDMA, isWord, isWrite, RegAddr, DataIn}
    localparam logic [26:0] STEPS [9] = '{
        {2'b01, 1'b0, 8'hC0, 16'h0000},
        {2'b01, 1'b1, 8'h10, 16'h0000},
        {2'b01, 1'b1, 8'h12, 16'h0E03},
        {2'b01, 1'b1, 8'h14, 16'hFA61},
        {2'b01, 1'b1, 8'h84, 16'h4000},
        {2'b01, 1'b1, 8'h86, 16'h4000},
        {2'b01, 1'b1, 8'h70, 16'h00EE},
        {2'b01, 1'b1, 8'h74, 16'h7CE0},
        {2'b01, 1'b0, 8'h74, 16'h0000}
    };

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        initReq = 1'b0;
    logic        cmdAck = 1'b0;
    logic        dataValid = 1'b0;
    logic [15:0] rdData = 16'h0000;
    logic        initAck, cmdReq, isDMA, isWrite, isWord;
    logic        initOK, ethIoError;
    logic [7:0]  RegAddr;
    logic [15:0] DataIn;
    logic [3:0]  errStep;

    always #5 sysclk = ~sysclk;

    ksz8851_init_seq dut (
        .sysclk(sysclk), .reset(reset), .initReq(initReq),
        .initAck(initAck), .cmdReq(cmdReq), .cmdAck(cmdAck),
        .dataValid(dataValid), .rdData(rdData), .isDMA(isDMA),
        .isWrite(isWrite), .isWord(isWord), .RegAddr(RegAddr),
        .DataIn(DataIn), .initOK(initOK), .ethIoError(ethIoError),
        .errStep(errStep)
    );

    int          checks = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned req12_cyc = 0;
    int unsigned err_cyc = 0;
    logic [26:0] cmd_q[$];
    logic [5:0]  res_q[$];
    logic [15:0] cider = 16'h8872;
    logic [15:0] rxcr1 = 16'h7CE0;
    logic [7:0]  noack_addr = 8'hFF;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Command monitor: every rising cmdReq must match the next queued command.
    logic req_p = 1'b0;
    always @(negedge sysclk) begin
        if (cmdReq && !req_p) begin
            if (RegAddr == 8'h12) req12_cyc = cyc;
            check("cmd_expected", 32'(cmd_q.size() != 0), 1);
            if (cmd_q.size() != 0)
                check("cmd", 32'({isDMA, isWord, isWrite, RegAddr, DataIn}),
                      32'(cmd_q.pop_front()));
        end
        req_p = cmdReq;
    end

    // Result monitor: each rising initOK/ethIoError must match the queued outcome.
    logic ok_p = 1'b0, err_p = 1'b0;
    always @(negedge sysclk) begin
        logic [5:0] e;
        if ((initOK && !ok_p) || (ethIoError && !err_p)) begin
            if (ethIoError) err_cyc = cyc;
            check("res_expected", 32'(res_q.size() != 0), 1);
            if (res_q.size() != 0) begin
                e = res_q.pop_front();
                check("initOK", 32'(initOK), 32'(e[5]));
                check("ethIoError", 32'(ethIoError), 32'(e[4]));
                if (e[4]) check("errStep", 32'(errStep), 32'(e[3:0]));
            end
        end
        if (initOK && ethIoError)
            check("ok_err_exclusive", 32'({initOK, ethIoError}), 0);
        ok_p = initOK;
        err_p = ethIoError;
    end

    // Driver model: ack after 3 cycles, read data follows ack, release on cmdReq low.
    initial begin
        int dcnt;
        int ds;
        dcnt = 0;
        ds = 0;
        forever begin
            @(negedge sysclk);
            if (!reset) begin
                cmdAck = 1'b0;
                dataValid = 1'b0;
                ds = 0;
                dcnt = 0;
            end else begin
                case (ds)
                    0: if (cmdReq) begin
                        dcnt++;
                        if (dcnt >= 3 && RegAddr != noack_addr) begin
                            cmdAck = 1'b1;
                            ds = 1;
                            dcnt = 0;
                        end
                    end else begin
                        dcnt = 0;
                    end
                    1: if (!cmdReq) begin
                        cmdAck = 1'b0;
                        ds = 0;
                    end else if (!isWrite) begin
                        rdData = (RegAddr == 8'hC0) ? cider : rxcr1;
                        dataValid = 1'b1;
                        ds = 2;
                    end
                    default: if (!cmdReq) begin
                        cmdAck = 1'b0;
                        dataValid = 1'b0;
                        ds = 0;
                    end
                endcase
            end
        end
    end

    task automatic push_cmds(input int n);
        for (int i = 0; i < n; i++) cmd_q.push_back(STEPS[i]);
    endtask

    task automatic start_init();
        @(negedge sysclk);
        initReq = 1'b1;
        @(negedge sysclk);
        initReq = 1'b0;
        check("initAck_pulse", 32'(initAck), 1);
        @(negedge sysclk);
        check("initAck_single", 32'(initAck), 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(initOK || ethIoError) && n < 5000) begin
            @(negedge sysclk);
            n++;
        end
        check("done_in_time", 32'(n < 5000), 1);
        repeat (4) @(negedge sysclk);
        check("cmd_q_drained", 32'(cmd_q.size()), 0);
        check("res_q_drained", 32'(res_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmdReq"}, 32'(cmdReq), 0);
        check({tag, "_initAck"}, 32'(initAck), 0);
        check({tag, "_initOK"}, 32'(initOK), 0);
        check({tag, "_ethIoError"}, 32'(ethIoError), 0);
        check({tag, "_isWrite"}, 32'(isWrite), 0);
        check({tag, "_isWord"}, 32'(isWord), 1);
        check({tag, "_RegAddr"}, 32'(RegAddr), 0);
        check({tag, "_DataIn"}, 32'(DataIn), 0);
        check({tag, "_errStep"}, 32'(errStep), 0);
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) @(negedge sysclk);
        reset = 1'b1;

        // Happy path
        push_cmds(NSTEP);
        res_q.push_back({1'b1, 1'b0, 4'd0});
        start_init();
        wait_done();

        // Chip ID mismatch: no write may follow the CIDER read
        cider = 16'h1234;
        push_cmds(1);
        res_q.push_back({1'b0, 1'b1, 4'd0});
        start_init();
        wait_done();
        check("cider_err_cmdReq", 32'(cmdReq), 0);
        cider = 16'h8872;

`ifdef INIT_READBACK_EN
        // RXCR1 readback mismatch
        rxcr1 = 16'h7CE1;
        push_cmds(9);
        res_q.push_back({1'b0, 1'b1, 4'd8});
        start_init();
        wait_done();
        rxcr1 = 16'h7CE0;
`endif

        // Ack timeout on step 2
        noack_addr = 8'h12;
        push_cmds(3);
        res_q.push_back({1'b0, 1'b1, 4'd2});
        start_init();
        wait_done();
        check("timeout_cycles", err_cyc - req12_cyc, 1024);
        noack_addr = 8'hFF;

        // Restart during step 4
        push_cmds(5);
        push_cmds(NSTEP);
        res_q.push_back({1'b1, 1'b0, 4'd0});
        start_init();
        n = 0;
        while (!(cmdReq && RegAddr == 8'h84) && n < 2000) begin
            @(negedge sysclk);
            n++;
        end
        check("reached_step4", 32'(n < 2000), 1);
        initReq = 1'b1;
        @(negedge sysclk);
        initReq = 1'b0;
        check("restart_cmdReq", 32'(cmdReq), 0);
        check("restart_initAck", 32'(initAck), 1);
        wait_done();

        // Asynchronous reset in the middle of the CIDER read
        push_cmds(1);
        start_init();
        n = 0;
        while (!dataValid && n < 2000) begin
            @(negedge sysclk);
            n++;
        end
        check("reached_read", 32'(n < 2000), 1);
        check("mid_read_cmdReq", 32'(cmdReq), 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async");
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        push_cmds(NSTEP);
        res_q.push_back({1'b1, 1'b0, 4'd0});
        start_init();
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
